// File: rtl/pixel_word_packer.sv
// Packs PIX_PER_WORD pixels from the D5M capture path into one frame-FIFO word.
// Frame-aware capture with single-shot / continuous modes, word limit and overflow flag.
module pixel_word_packer #(
   parameter int PIX_W        = 12,
   parameter int PIX_PER_WORD = 3,
   parameter int CNT_W        = 20
) (
   input  logic                          D5M_PIXLCLK,
   input  logic                          RST_N,
   input  logic                          iFVAL,
   input  logic [PIX_W-1:0]              iDATA,
   input  logic                          iDATA_VAL,
   input  logic                          iARM,
   input  logic                          iABORT,
   input  logic                          iMODE,
   input  logic [CNT_W-1:0]              iWORD_LIMIT,
   input  logic                          iFIFO_FULL,
   output logic [PIX_W*PIX_PER_WORD-1:0] oWORD,
   output logic                          oWRREQ,
   output logic [CNT_W-1:0]              oWORD_COUNT,
   output logic [7:0]                    oFRAME_COUNT,
   output logic                          oBUSY,
   output logic                          oDONE,
   output logic                          oOVERFLOW
);

   localparam int WORD_W = PIX_W * PIX_PER_WORD;
   localparam int IDX_W  = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_PER_WORD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_SOF = 3'd1,
      S_CAPTURE  = 3'd2,
      S_WAIT_EOF = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic               r_fval;
   logic [IDX_W-1:0]   r_idx;
   logic [PIX_W-1:0]   r_pix [PIX_PER_WORD];
   logic [WORD_W-1:0]  r_word;
   logic               r_wrreq;
   logic [CNT_W-1:0]   r_word_count;
   logic [7:0]         r_frame_count;
   logic               r_busy;
   logic               r_done;
   logic               r_overflow;

   logic               w_sof;
   logic               w_eof;
   logic               w_pix;
   logic               w_take;
   logic               w_clr_cnt;
   logic               w_frame_inc;
   logic               w_ovf_clr;
   logic               w_limit_hit;
   logic               w_last;
   logic               w_write;
   logic [IDX_W-1:0]   w_base_idx;
   logic [WORD_W-1:0]  w_word;
   logic [CNT_W-1:0]   w_cnt_base;

   assign w_sof       = iFVAL & ~r_fval;
   assign w_eof       = ~iFVAL & r_fval;
   assign w_pix       = iFVAL & iDATA_VAL;
   assign w_limit_hit = (iWORD_LIMIT != CNT_ZERO) && (r_word_count == iWORD_LIMIT);
   assign w_last      = w_take & (w_base_idx == LAST_IDX);
   assign w_write     = w_last & ~iFIFO_FULL;
   assign w_cnt_base  = w_clr_cnt ? CNT_ZERO : r_word_count;

   assign oWORD        = r_word;
   assign oWRREQ       = r_wrreq;
   assign oWORD_COUNT  = r_word_count;
   assign oFRAME_COUNT = r_frame_count;
   assign oBUSY        = r_busy;
   assign oDONE        = r_done;
   assign oOVERFLOW    = r_overflow;

   // State register
   always_ff @(posedge D5M_PIXLCLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and per-cycle datapath controls; abort overrides everything
   always_comb begin
      w_next      = r_state;
      w_take      = 1'b0;
      w_clr_cnt   = 1'b0;
      w_frame_inc = 1'b0;
      w_ovf_clr   = 1'b0;
      w_base_idx  = r_idx;
      if (iABORT) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (iARM) begin
                  w_next = S_WAIT_SOF;
               end else begin
                  w_next = S_IDLE;
               end
            end
            S_WAIT_SOF: begin
               if (w_sof) begin
                  w_next     = S_CAPTURE;
                  w_clr_cnt  = 1'b1;
                  w_base_idx = {IDX_W{1'b0}};
                  w_take     = w_pix;
               end else begin
                  w_next = S_WAIT_SOF;
               end
            end
            S_CAPTURE: begin
               // EOF wins over a limit hit so the frame still gets counted
               if (w_eof) begin
                  w_frame_inc = 1'b1;
                  w_next      = iMODE ? S_WAIT_SOF : S_DONE;
               end else if (w_limit_hit) begin
                  w_next = iMODE ? S_WAIT_EOF : S_DONE;
               end else begin
                  w_take = w_pix;
               end
            end
            S_WAIT_EOF: begin
               if (w_eof) begin
                  w_frame_inc = 1'b1;
                  w_next      = S_WAIT_SOF;
               end else begin
                  w_next = S_WAIT_EOF;
               end
            end
            S_DONE: begin
               if (iARM) begin
                  w_next    = S_WAIT_SOF;
                  w_ovf_clr = 1'b1;
               end else begin
                  w_next = S_DONE;
               end
            end
            default: begin
               w_next = S_IDLE;
            end
         endcase
      end
   end

   // Assemble the completed word: stored pixels plus the one arriving now
   always_comb begin
      w_word = {WORD_W{1'b0}};
      for (int i = 0; i < PIX_PER_WORD; i++) begin
         if (i == PIX_PER_WORD - 1) begin
            w_word[i*PIX_W +: PIX_W] = iDATA;
         end else begin
            w_word[i*PIX_W +: PIX_W] = r_pix[i];
         end
      end
   end

   // Pixel slot storage and slot index
   always_ff @(posedge D5M_PIXLCLK or negedge RST_N) begin
      if (!RST_N) begin
         r_idx <= {IDX_W{1'b0}};
         for (int i = 0; i < PIX_PER_WORD; i++) begin
            r_pix[i] <= {PIX_W{1'b0}};
         end
      end else begin
         if (w_take) begin
            r_pix[w_base_idx] <= iDATA;
            r_idx <= (w_base_idx == LAST_IDX) ? {IDX_W{1'b0}} : (w_base_idx + IDX_W'(1));
         end else if (w_next != S_CAPTURE) begin
            r_idx <= {IDX_W{1'b0}};
         end else begin
            r_idx <= r_idx;
         end
      end
   end

   // Output word, strobe, counters and status flags
   always_ff @(posedge D5M_PIXLCLK or negedge RST_N) begin
      if (!RST_N) begin
         r_fval        <= 1'b0;
         r_word        <= {WORD_W{1'b0}};
         r_wrreq       <= 1'b0;
         r_word_count  <= CNT_ZERO;
         r_frame_count <= 8'd0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         r_fval  <= iFVAL;
         r_wrreq <= w_write;
         if (w_write) begin
            r_word <= w_word;
         end else begin
            r_word <= r_word;
         end
         if (w_write && (w_cnt_base != CNT_MAX)) begin
            r_word_count <= w_cnt_base + CNT_W'(1);
         end else begin
            r_word_count <= w_cnt_base;
         end
         if (w_frame_inc) begin
            r_frame_count <= r_frame_count + 8'd1;
         end else begin
            r_frame_count <= r_frame_count;
         end
         // A full FIFO on a word's last pixel drops the word and latches overflow
         if (w_last && iFIFO_FULL) begin
            r_overflow <= 1'b1;
         end else if (w_ovf_clr) begin
            r_overflow <= 1'b0;
         end else begin
            r_overflow <= r_overflow;
         end
         r_busy <= (w_next == S_WAIT_SOF) || (w_next == S_CAPTURE) || (w_next == S_WAIT_EOF);
         r_done <= (w_next == S_DONE);
      end
   end

endmodule
